// File: rtl/axis_adc_packer.sv
// axis_adc_packer: packs sign-extended ADC samples into LANES-wide beats,
// frames them FRAME_LEN beats per packet and queues them on an AXI-Stream
// master through a small FIFO that drops (and flags) beats when full.
// Ports:
//   clk, aresetn            clock, async active-low reset
//   adc_data_in/_valid      sample input
//   enable                  start (IDLE->RUN) / stop (RUN->DRAIN) capture
//   m_axis_tdata/tvalid/tready/tlast  AXI-Stream master
//   overflow                sticky beat-dropped flag
//   busy                    state is not IDLE
module axis_adc_packer #(
   parameter int ADC_WIDTH  = 14,
   parameter int LANE_WIDTH = 16,
   parameter int LANES      = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int FRAME_LEN  = 4
) (
   input  logic                        clk,
   input  logic                        aresetn,
   input  logic [ADC_WIDTH-1:0]        adc_data_in,
   input  logic                        adc_data_valid,
   input  logic                        enable,
   output logic [LANES*LANE_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        overflow,
   output logic                        busy
);

   localparam int DATA_W = LANES * LANE_WIDTH;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [LIDX_W-1:0]   lane_q, lane_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   beat_q, beat_d;
   logic                overflow_q, overflow_d;
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic                mem_last_q [FIFO_DEPTH];

   logic                    empty;
   logic                    full;
   logic                    pop;
   logic                    capture;
   logic                    last_lane;
   logic                    push;
   logic                    wr_last;
   logic signed [LANE_WIDTH-1:0] sample_ext;

   // pointers carry one extra wrap bit: equal -> empty, MSB differs -> full
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = !empty && m_axis_tready;

   assign sample_ext = LANE_WIDTH'($signed(adc_data_in));

   // enable is gated in so the sample on the stop cycle is not taken
   assign capture   = (state_q == S_RUN) && enable && adc_data_valid;
   assign last_lane = (lane_q == LIDX_W'(LANES - 1));
   // a full FIFO still accepts the beat if the head leaves on this edge
   assign push      = capture && last_lane && (!full || pop);
   assign wr_last   = (cnt_q == CNT_W'(FRAME_LEN - 1));

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      cnt_d      = cnt_q;
      beat_d     = beat_q;
      overflow_d = overflow_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d    = S_RUN;
               overflow_d = 1'b0;
               lane_d     = '0;
               cnt_d      = '0;
            end
         end
         S_RUN: begin
            if (!enable) begin
               state_d = S_DRAIN;
               lane_d  = '0;
            end else if (adc_data_valid) begin
               for (int k = 0; k < LANES; k++) begin
                  if (lane_q == LIDX_W'(k))
                     beat_d[k*LANE_WIDTH +: LANE_WIDTH] = sample_ext;
               end
               if (last_lane) begin
                  lane_d = '0;
                  if (push)
                     cnt_d = wr_last ? '0 : cnt_q + CNT_W'(1);
                  else
                     overflow_d = 1'b1;
               end else begin
                  lane_d = lane_q + LIDX_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (empty) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= S_IDLE;
         lane_q     <= '0;
         cnt_q      <= '0;
         beat_q     <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         cnt_q      <= cnt_d;
         beat_q     <= beat_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // storage array needs no reset: it is only visible when non-empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]]      <= beat_d;
         mem_last_q[wr_ptr_q[AW-1:0]] <= wr_last;
      end
   end

   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign m_axis_tlast  = empty ? 1'b0 : mem_last_q[rd_ptr_q[AW-1:0]];
   assign overflow      = overflow_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_axis_adc_packer.sv
// tb_axis_adc_packer: directed self-checking bench for axis_adc_packer
// with default parameters (14-bit samples, 2x16-bit lanes, depth 4, frame 4).
module tb_axis_adc_packer;

   logic        clk;
   logic        aresetn;
   logic [13:0] adc_data_in;
   logic        adc_data_valid;
   logic        enable;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        overflow;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] got_data[$];
   logic        got_last[$];

   axis_adc_packer dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .adc_data_in   (adc_data_in),
      .adc_data_valid(adc_data_valid),
      .enable        (enable),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .overflow      (overflow),
      .busy          (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // drive one cycle of inputs at a falling edge, log any handshake that
   // the next rising edge will complete, then advance to the next fall
   task automatic step(input logic v, input logic [13:0] d,
                       input logic rdy, input logic en);
      adc_data_valid = v;
      adc_data_in    = d;
      m_axis_tready  = rdy;
      enable         = en;
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
         got_data.push_back(m_axis_tdata);
         got_last.push_back(m_axis_tlast);
      end
      @(negedge clk);
   endtask

   task automatic restart();
      int n = 0;
      step(1'b0, 14'h0, 1'b1, 1'b0);
      while (busy && n < 20) begin
         step(1'b0, 14'h0, 1'b1, 1'b0);
         n++;
      end
      checks++;
      if (busy !== 1'b0)
         $display("FAIL restart_idle: busy=%b required 0", busy);
      if (busy !== 1'b0) errors++;
      step(1'b0, 14'h0, 1'b1, 1'b1);
   endtask

   task automatic test_reset();
      aresetn        = 1'b0;
      enable         = 1'b1;
      m_axis_tready  = 1'b0;
      adc_data_in    = 14'h155;
      adc_data_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         adc_data_valid = i[0];
         @(negedge clk);
         checks++;
         if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata,
              overflow, busy} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: tvalid=%b tlast=%b tdata=%h ovf=%b busy=%b required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, overflow, busy);
         end
      end
      adc_data_valid = 1'b0;
      aresetn        = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b required 0", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_enable_busy: busy=%b required 1", busy);
      end
   endtask

   task automatic test_sign_extend();
      got_data.delete();
      got_last.delete();
      step(1'b1, 14'h1FFF, 1'b1, 1'b1);
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL sx_early_valid: tvalid=%b required 0", m_axis_tvalid);
      end
      step(1'b1, 14'h2000, 1'b1, 1'b1);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hE0001FFF) begin
         errors++;
         $display("FAIL sx_beat: tvalid=%b tdata=%h required 1 e0001fff",
                  m_axis_tvalid, m_axis_tdata);
      end
      step(1'b0, 14'h0, 1'b1, 1'b1);
      checks++;
      if (m_axis_tvalid !== 1'b0 || got_data.size() != 1) begin
         errors++;
         $display("FAIL sx_one_cycle: tvalid=%b beats=%0d required 0 1",
                  m_axis_tvalid, got_data.size());
      end
   endtask

   task automatic test_frame();
      logic [31:0] exp_d [4];
      exp_d = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007};
      restart();
      got_data.delete();
      got_last.delete();
      for (int i = 1; i <= 8; i++) step(1'b1, 14'(i), 1'b1, 1'b1);
      repeat (3) step(1'b0, 14'h0, 1'b1, 1'b1);
      checks++;
      if (got_data.size() != 4) begin
         errors++;
         $display("FAIL frame_count: beats=%0d required 4", got_data.size());
      end
      for (int i = 0; i < 4 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL frame_beat%0d: tdata=%h tlast=%b required %h %b",
                     i, got_data[i], got_last[i], exp_d[i], (i == 3));
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_d [4];
      exp_d = '{32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007};
      restart();
      got_data.delete();
      got_last.delete();
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 14'(i), 1'b0, 1'b1);
         if (m_axis_tvalid) begin
            checks++;
            if (m_axis_tdata !== 32'h00020001 || m_axis_tlast !== 1'b0) begin
               errors++;
               $display("FAIL ovf_hold: tdata=%h tlast=%b required 00020001 0",
                        m_axis_tdata, m_axis_tlast);
            end
         end
      end
      checks++;
      if (overflow !== 1'b1 || m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag: overflow=%b tvalid=%b required 1 1",
                  overflow, m_axis_tvalid);
      end
      repeat (6) step(1'b0, 14'h0, 1'b1, 1'b1);
      checks++;
      if (got_data.size() != 4) begin
         errors++;
         $display("FAIL ovf_count: beats=%0d required 4", got_data.size());
      end
      for (int i = 0; i < 4 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL ovf_beat%0d: tdata=%h tlast=%b required %h %b",
                     i, got_data[i], got_last[i], exp_d[i], (i == 3));
         end
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: overflow=%b required 1", overflow);
      end
   endtask

   task automatic test_stop_drain();
      logic [31:0] exp_d [4];
      int n = 0;
      exp_d = '{32'h01020101, 32'h01040103, 32'h01060105, 32'h01080107};
      got_data.delete();
      got_last.delete();
      step(1'b1, 14'h011, 1'b0, 1'b1);
      step(1'b1, 14'h022, 1'b0, 1'b1);
      step(1'b1, 14'h033, 1'b0, 1'b1);
      step(1'b0, 14'h0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL stop_drain_state: busy=%b tvalid=%b required 1 1",
                  busy, m_axis_tvalid);
      end
      while (busy && n < 20) begin
         step(1'b0, 14'h0, 1'b1, 1'b0);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_idle: busy=%b required 0", busy);
      end
      checks++;
      if (got_data.size() != 1 || got_data[0] !== 32'h00220011) begin
         errors++;
         $display("FAIL stop_partial_dropped: beats=%0d first=%h required 1 00220011",
                  got_data.size(), got_data.size() ? got_data[0] : 32'h0);
      end
      step(1'b0, 14'h0, 1'b1, 1'b1);
      checks++;
      if (overflow !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reenable: overflow=%b busy=%b required 0 1",
                  overflow, busy);
      end
      got_data.delete();
      got_last.delete();
      for (int i = 1; i <= 8; i++)
         step(1'b1, 14'h100 + 14'(i), 1'b1, 1'b1);
      repeat (3) step(1'b0, 14'h0, 1'b1, 1'b1);
      checks++;
      if (got_data.size() != 4) begin
         errors++;
         $display("FAIL reenable_count: beats=%0d required 4", got_data.size());
      end
      for (int i = 0; i < 4 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL reenable_beat%0d: tdata=%h tlast=%b required %h %b",
                     i, got_data[i], got_last[i], exp_d[i], (i == 3));
         end
      end
   endtask

   task automatic test_reset_midrun();
      restart();
      got_data.delete();
      got_last.delete();
      for (int i = 1; i <= 6; i++) step(1'b1, 14'(i), 1'b0, 1'b1);
      checks++;
      if (m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL mid_queued: tvalid=%b required 1", m_axis_tvalid);
      end
      aresetn = 1'b0;
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata,
           overflow, busy} !== 36'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: tvalid=%b tlast=%b tdata=%h ovf=%b busy=%b required all 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, overflow, busy);
      end
      @(negedge clk);
      @(negedge clk);
      enable         = 1'b0;
      adc_data_valid = 1'b0;
      aresetn        = 1'b1;
      repeat (5) step(1'b0, 14'h0, 1'b1, 1'b0);
      checks++;
      if (got_data.size() != 0 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_no_output: beats=%0d tvalid=%b busy=%b required 0 0 0",
                  got_data.size(), m_axis_tvalid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_sign_extend();
      test_frame();
      test_overflow();
      test_stop_drain();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
